// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the pipeline stage registers.
package pipeline_pkg;

    localparam int CTRL_W             = 4;
    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_REG_ADDR_W = 5;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ex_mem_ctrl_t;

    // A bubble must never present an active memory or write-back strobe.
    function automatic ex_mem_ctrl_t gate_ctrl(input logic valid, input ex_mem_ctrl_t ctrl);
        return valid ? ctrl : '0;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+payload holding register; clear wins over load, payload is kept on clear.
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] payload
);

    logic         valid_d, valid_q;
    logic [W-1:0] payload_d, payload_q;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d   = 1'b1;
            payload_d = d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid   = valid_q;
    assign payload = payload_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register: main + skid entries under valid/ready, with flush
// and a saturating stall counter.
module ex_mem_pipe_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int PAY_W = 2 * DATA_W + REG_ADDR_W + CTRL_W;

    logic [PAY_W-1:0] in_payload;
    logic [PAY_W-1:0] main_payload;
    logic [PAY_W-1:0] skid_payload;
    logic [PAY_W-1:0] main_load_data;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;
    logic             rel;
    logic             main_free;
    logic             main_load;
    logic             main_clear;
    logic             skid_load;
    logic             skid_clear;
    ex_mem_ctrl_t     held_ctrl;
    logic [CNT_W-1:0] stall_count_d, stall_count_q;

    assign in_payload = {in_result, in_store_data, in_dest, in_ctrl};

    // in_ready comes straight from the skid valid flop, so out_ready never reaches EX.
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign rel       = main_valid & out_ready;
    assign main_free = ~main_valid | rel;

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_load_data = in_payload;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (main_free) begin
            if (skid_valid) begin
                main_load      = 1'b1;
                main_load_data = skid_payload;
                skid_clear     = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else if (accept) begin
            skid_load = 1'b1;
        end
    end

    pipe_skid_slot #(.W(PAY_W)) u_main (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (main_load),
        .clear   (main_clear),
        .d       (main_load_data),
        .valid   (main_valid),
        .payload (main_payload)
    );

    pipe_skid_slot #(.W(PAY_W)) u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d       (in_payload),
        .valid   (skid_valid),
        .payload (skid_payload)
    );

    assign {out_result, out_store_data, out_dest, held_ctrl} = main_payload;
    assign out_valid = main_valid;
    assign out_ctrl  = gate_ctrl(main_valid, held_ctrl);

    // Counts cycles MEM refused a valid instruction; survives flush, sticks at all-ones.
    always_comb begin
        stall_count_d = stall_count_q;
        if (main_valid && !out_ready && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Self-checking bench for ex_mem_pipe_stage: directed plan then random traffic against a queue model.
module tb_ex_mem_pipe_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_result = '0;
    logic [31:0] in_store_data = '0;
    logic [4:0]  in_dest = '0;
    logic [3:0]  in_ctrl = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_dest;
    logic [3:0]  out_ctrl;
    logic [15:0] stall_count;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_result, s_out_store_data;
    logic [4:0]  s_out_dest;
    logic [3:0]  s_out_ctrl;
    logic [3:0]  s_stall_count;

    always #5 clock = ~clock;

    ex_mem_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_store_data(in_store_data), .in_dest(in_dest),
        .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_dest(out_dest),
        .out_ctrl(out_ctrl), .stall_count(stall_count)
    );

    ex_mem_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut_sat (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_result(in_result), .in_store_data(in_store_data), .in_dest(in_dest),
        .in_ctrl(in_ctrl), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_result(s_out_result), .out_store_data(s_out_store_data), .out_dest(s_out_dest),
        .out_ctrl(s_out_ctrl), .stall_count(s_stall_count)
    );

    typedef struct {
        logic [31:0] r;
        logic [31:0] s;
        logic [4:0]  d;
        logic [3:0]  c;
    } ent_t;

    int          compared = 0;
    int          mismatched = 0;
    ent_t        q[$];
    ent_t        last_shown;
    ent_t        cur;
    int          exp_stall;
    logic [31:0] seq;
    logic [31:0] exp_next_out;

    function automatic ent_t make_entry(input logic [31:0] r);
        ent_t e;
        e.r = r;
        e.s = $urandom;
        e.d = 5'($urandom);
        e.c = 4'($urandom);
        return e;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compares every DUT output against the queue model's current state.
    task automatic checkOutput();
        ent_t        sh;
        logic        ev;
        logic [31:0] st16, st4;
        ev = (q.size() > 0);
        if (ev) begin
            sh = q[0];
            last_shown = sh;
        end else begin
            sh = last_shown;
        end
        st16 = (exp_stall > 65535) ? 32'd65535 : 32'(exp_stall);
        st4  = (exp_stall > 15) ? 32'd15 : 32'(exp_stall);
        chk32("out_valid", 32'(out_valid), 32'(ev));
        chk32("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk32("out_result", out_result, sh.r);
        chk32("out_store_data", out_store_data, sh.s);
        chk32("out_dest", 32'(out_dest), 32'(sh.d));
        chk32("out_ctrl", 32'(out_ctrl), ev ? 32'(sh.c) : 32'd0);
        chk32("stall_count", 32'(stall_count), st16);
        chk32("sat_out_valid", 32'(s_out_valid), 32'(ev));
        chk32("sat_in_ready", 32'(s_in_ready), 32'(q.size() < 2));
        chk32("sat_out_result", s_out_result, sh.r);
        chk32("sat_out_store_data", s_out_store_data, sh.s);
        chk32("sat_out_dest", 32'(s_out_dest), 32'(sh.d));
        chk32("sat_out_ctrl", 32'(s_out_ctrl), ev ? 32'(sh.c) : 32'd0);
        chk32("sat_stall_count", 32'(s_stall_count), st4);
    endtask

    // Drives one cycle of inputs, checks, clocks, then advances the model.
    task automatic applyStimulus(input bit iv, input bit orr, input bit fl);
        bit acc;
        in_valid  = iv;
        out_ready = orr;
        flush     = fl;
        if (iv) begin
            in_result     = cur.r;
            in_store_data = cur.s;
            in_dest       = cur.d;
            in_ctrl       = cur.c;
        end else begin
            in_result     = $urandom;
            in_store_data = $urandom;
            in_dest       = 5'($urandom);
            in_ctrl       = 4'hF;
        end
        checkOutput();
        if (q.size() > 0 && orr) begin
            chk32("order", out_result, exp_next_out);
            exp_next_out = exp_next_out + 32'd1;
        end
        acc = iv && (q.size() < 2);
        @(posedge clock);
        if (q.size() > 0 && !orr) exp_stall++;
        if (q.size() > 0 && orr) void'(q.pop_front());
        if (fl) begin
            q.delete();
        end else if (acc) begin
            q.push_back(cur);
        end
        if (acc) begin
            seq = seq + 32'd1;
            cur = make_entry(seq);
        end
        if (fl) exp_next_out = seq;
        #1;
    endtask

    task automatic doReset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        q.delete();
        exp_stall    = 0;
        last_shown   = '{default: '0};
        seq          = 32'h10;
        cur          = make_entry(seq);
        exp_next_out = seq;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] start");
        doReset();
        checkOutput();
        chk32("reset_out_ctrl", 32'(out_ctrl), 32'd0);
        chk32("reset_in_ready", 32'(in_ready), 32'd1);

        // Streaming with MEM always ready: values 0x10..0x17.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0);

        // Backpressure for three cycles, then drain in order.
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        chk32("bp_stall_count", 32'(stall_count), 32'd3);
        chk32("bp_in_ready", 32'(in_ready), 32'd0);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0);

        // Fill both entries, then flush with a valid input offered.
        applyStimulus(1'b1, 1'b0, 1'b0);
        chk32("pre_flush_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        chk32("post_flush_out_valid", 32'(out_valid), 32'd0);
        chk32("post_flush_in_ready", 32'(in_ready), 32'd1);

        // Bubbles with all control bits set on the input.
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0);

        // Saturation of the narrow counter.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);
        chk32("sat_stuck_15", 32'(s_stall_count), 32'd15);
        chk32("wide_count_20", 32'(stall_count), 32'd20);
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

        // Asynchronous reset with the skid entry full.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        chk32("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk32("async_out_valid", 32'(out_valid), 32'd0);
        chk32("async_in_ready", 32'(in_ready), 32'd1);
        chk32("async_sat_out_valid", 32'(s_out_valid), 32'd0);
        chk32("async_stall_count", 32'(stall_count), 32'd0);
        doReset();
        checkOutput();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_stage.md
# ex_mem_pipe_stage

Parametrised EX/MEM pipeline register that replaces the fixed two-word EX/MEM latch. It carries the ALU result, store data, destination register and memory/write-back control bits from EX to MEM under a valid/ready handshake. A two-entry (main + skid) buffer lets MEM stall without a combinational ready path back into EX. It adds synchronous flush for branch/exception squash and a saturating stall counter for performance debug.

## Interface
- DATA_W, 32, width of result and store data
- REG_ADDR_W, 5, width of destination register index
- CNT_W, 16, width of stall counter
- clock  in  1  rising-edge clock, single domain
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept (registered)
- in_result  in  DATA_W  ALU result / address
- in_store_data  in  DATA_W  second register operand (store data)
- in_dest  in  REG_ADDR_W  destination register
- in_ctrl  in  4  {mem_read, mem_write, reg_write, mem_to_reg}
- flush  in  1  squash all held and incoming entries
- out_valid  out  1  MEM side holds a valid instruction
- out_ready  in  1  MEM consumes this cycle
- out_result, out_store_data, out_dest, out_ctrl  out  as inputs  registered payload
- stall_count  out  CNT_W  saturating count of stalled cycles

## Operation
- Storage: main entry (drives outputs) and skid entry, each {valid, payload}.
- in_ready = !skid_valid, taken from a flop; no combinational path from out_ready.
- accept = in_valid & in_ready; release = out_valid & out_ready; main_free = !main_valid | release.
- Per cycle, no flush:
  - main_free & skid_valid: main <= skid, skid_valid <= 0.
  - main_free & !skid_valid: main_valid <= accept; payload loaded on accept.
  - !main_free & accept: skid <= input, skid_valid <= 1.
  - Otherwise hold.
- Flush: main_valid, skid_valid <= 0. The input offered that cycle is dropped even if accept is high. A release in the same cycle still completes on the MEM side. Flush has priority over every load.
- out_ctrl is gated with out_valid: a bubble never asserts mem_read, mem_write or reg_write. Payload data fields hold their last value when invalid.
- stall_count increments when out_valid & !out_ready and saturates at 2^CNT_W-1. It is not cleared by flush.
- Payload flops have no functional reset requirement beyond the values listed below.

## Timing
- Reset: main_valid = skid_valid = 0, out_valid = 0, in_ready = 1, out_ctrl = 0, payload outputs = 0, stall_count = 0.
- Latency: accepted in cycle N, visible on outputs in cycle N+1.
- Throughput: 1 per cycle while out_ready = 1.
- Stall entry: out_ready drops with main full. One more input can be accepted into skid, then in_ready = 0 from the next cycle.
- Stall exit: the first release moves skid to main. in_ready returns to 1 the following cycle. Order is preserved: main then skid then new input.
- Simultaneous flush and out_ready: the current output transfers and the stage is empty next cycle.
- Reset asserted mid-transfer clears both entries immediately, with no release.

## Structure
- pipeline_pkg holds:
  - the ex_mem_ctrl_t packed typedef {mem_read, mem_write, reg_write, mem_to_reg}
  - the CTRL_W = 4 constant
  - the default DATA_W / REG_ADDR_W constants shared with the other stage registers
- One sub-module, pipe_skid_slot: a single valid+payload register with load/clear, instantiated twice (main, skid). The top holds the steering logic and the stall counter.

## Test plan
- Reset then stream 8 inputs (result = 0x10..0x17) with out_ready = 1 -> same values on out_result one cycle later, in_ready constantly 1, stall_count = 0.
- Backpressure: drop out_ready for 3 cycles mid-stream -> exactly one extra input is accepted, in_ready = 0 afterwards, stall_count = 3. On release, output order is strictly 0x10, 0x11, 0x12... with no loss or duplication.
- Flush while main and skid are full and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and none of the three entries ever appears on the output.
- Bubble: in_valid = 0 with in_ctrl = 4'b1111 -> out_ctrl stays 0 while out_valid = 0.
- Saturation: CNT_W = 4, hold out_valid with out_ready = 0 for 20 cycles -> stall_count sticks at 15.
- Async reset pulse while skid is full -> out_valid and in_ready change without a clock edge, to 0 and 1 respectively.
